// File: rtl/reg_bank.sv
// ============================================================================
// reg_bank : register file with 1-cycle reads, write-through bypass and a
//            background debug scan port.  Rev 1.0
// ============================================================================
`default_nettype none

module reg_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] busA,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] busC,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              dbg_start,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_done
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  scan_state_e       state_q, state_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              dbg_done_q, dbg_done_d;

  logic              wr_hit;
  assign wr_hit = wr_en && (busC != '0);

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[busC] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      if (busA == '0) begin
        rd_data_d = '0;
      end else if (wr_hit && (busA == busC)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_q[busA];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // dbg_addr_q doubles as the scan index; outputs describe the beat shown
  // after the edge, and memory is sampled before that edge's write lands.
  always_comb begin
    state_d     = state_q;
    dbg_valid_d = 1'b0;
    dbg_addr_d  = dbg_addr_q;
    dbg_data_d  = dbg_data_q;
    dbg_done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dbg_start) begin
          state_d     = S_SCAN;
          dbg_valid_d = 1'b1;
          dbg_addr_d  = FIRST_IDX;
          dbg_data_d  = mem_q[FIRST_IDX];
          dbg_done_d  = (FIRST_IDX == LAST_IDX);
        end
      end
      S_SCAN: begin
        if (dbg_addr_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          dbg_valid_d = 1'b1;
          dbg_addr_d  = dbg_addr_q + FIRST_IDX;
          dbg_data_d  = mem_q[dbg_addr_d];
          dbg_done_d  = (dbg_addr_d == LAST_IDX);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dbg_valid_q <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_data_q  <= '0;
      dbg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_data_q  <= dbg_data_d;
      dbg_done_q  <= dbg_done_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign dbg_valid = dbg_valid_q;
  assign dbg_addr  = dbg_addr_q;
  assign dbg_data  = dbg_data_q;
  assign dbg_done  = dbg_done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// ============================================================================
// tb_reg_bank : directed self-checking bench for reg_bank.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_bank;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] busA;
  logic              rd_en;
  logic [ADDR_W-1:0] busC;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              dbg_start;
  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_done;

  int checks = 0;
  int failures = 0;

  reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .busA      (busA),
    .rd_en     (rd_en),
    .busC      (busC),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .dbg_start (dbg_start),
    .dbg_valid (dbg_valid),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_done  (dbg_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; busC = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    rd_en = 1'b1; busA = a;
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_data"}, 32'(rd_data), 32'(exp));
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
  endtask

  initial begin
    int beats;
    int done_cnt;
    reset_n = 1'b0; busA = '0; rd_en = 1'b0; busC = '0; wr_en = 1'b0;
    wr_data = '0; dbg_start = 1'b0;
    repeat (3) tick();
    check_eq("rst_rd_data", 32'(rd_data), 32'h0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
    check_eq("rst_dbg_valid", 32'(dbg_valid), 32'h0);
    check_eq("rst_dbg_done", 32'(dbg_done), 32'h0);
    reset_n = 1'b1;
    tick();

    // Reset mid-operation must clear written contents.
    do_write(6'd5, 16'hA5A5);
    do_read("pre_rst_r5", 6'd5, 16'hA5A5);
    reset_n = 1'b0;
    repeat (3) tick();
    check_eq("rst2_rd_data", 32'(rd_data), 32'h0);
    reset_n = 1'b1;
    tick();
    do_read("post_rst_r5", 6'd5, 16'h0000);
    tick();
    check_eq("rd_valid_one_cycle", 32'(rd_valid), 32'h0);

    // Write then read.
    do_write(6'd12, 16'hBEEF);
    do_read("wr_rd_r12", 6'd12, 16'hBEEF);
    tick();
    check_eq("rd_hold_data", 32'(rd_data), 32'hBEEF);
    check_eq("rd_hold_valid", 32'(rd_valid), 32'h0);

    // Same address on both buses with only a write: rd_data must not move.
    busA = 6'd9;
    do_write(6'd9, 16'h5555);
    check_eq("wr_only_no_rd", 32'(rd_data), 32'hBEEF);
    check_eq("wr_only_no_valid", 32'(rd_valid), 32'h0);
    do_read("r9", 6'd9, 16'h5555);

    // Collision bypass.
    do_write(6'd7, 16'h0001);
    rd_en = 1'b1; wr_en = 1'b1; busA = 6'd7; busC = 6'd7; wr_data = 16'h1234;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check_eq("bypass_data", 32'(rd_data), 32'h1234);
    check_eq("bypass_valid", 32'(rd_valid), 32'h1);
    do_read("after_bypass_r7", 6'd7, 16'h1234);

    // Register 0.
    do_write(6'd0, 16'hFFFF);
    do_read("r0_read", 6'd0, 16'h0000);
    rd_en = 1'b1; wr_en = 1'b1; busA = 6'd0; busC = 6'd0; wr_data = 16'hABCD;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check_eq("r0_collision", 32'(rd_data), 32'h0);

    // Full scan with preload i*3.
    for (int i = 1; i < 64; i++) do_write(6'(i), 16'(i * 3));
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    for (int b = 1; b < 64; b++) begin
      check_eq($sformatf("scan_valid_%0d", b), 32'(dbg_valid), 32'h1);
      check_eq($sformatf("scan_addr_%0d", b), 32'(dbg_addr), 32'(b));
      check_eq($sformatf("scan_data_%0d", b), 32'(dbg_data), 32'(b * 3));
      check_eq($sformatf("scan_done_%0d", b), 32'(dbg_done), (b == 63) ? 32'h1 : 32'h0);
      dbg_start = (b == 10) || (b == 63);
      tick();
      dbg_start = 1'b0;
    end
    check_eq("scan_end_valid", 32'(dbg_valid), 32'h0);
    check_eq("scan_end_done", 32'(dbg_done), 32'h0);
    tick();
    check_eq("scan_no_restart", 32'(dbg_valid), 32'h0);

    // Reset at beat 20.
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    repeat (19) tick();
    check_eq("beat20_addr", 32'(dbg_addr), 32'd20);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(dbg_valid), 32'h0);
    check_eq("midrst_done", 32'(dbg_done), 32'h0);
    check_eq("midrst_addr", 32'(dbg_addr), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("idle_after_rst", 32'(dbg_valid), 32'h0);

    // Fresh scan after reset: bank is all zero.
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    beats = 0;
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (dbg_valid) begin
        beats++;
        if (dbg_data !== '0) check_eq("rescan_data_zero", 32'(dbg_data), 32'h0);
        if (dbg_done) begin
          done_cnt++;
          check_eq("rescan_done_addr", 32'(dbg_addr), 32'd63);
        end
      end
      tick();
    end
    check_eq("rescan_beats", 32'(beats), 32'd63);
    check_eq("rescan_done_cnt", 32'(done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Register file at the far end of the micro-sequencer's register-address buses.
- Consumes the read address on bus A and the write address on bus C, holds the architectural registers, and returns operand data one cycle after a read strobe.
- Includes a sequential debug scan port that walks every register without stalling normal reads and writes.
- Sits between the bus-A/bus-C address mux and the ALU/datapath.

Parameters:
- DATA_W, 16, width of each register and of the data buses.
- ADDR_W, 6, width of busA/busC; the bank holds 2**ADDR_W registers.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- busA  in  ADDR_W  read register address.
- rd_en  in  1  read strobe; samples busA.
- busC  in  ADDR_W  write register address.
- wr_en  in  1  write strobe; samples busC and wr_data.
- wr_data  in  DATA_W  data to write.
- rd_data  out  DATA_W  registered read result.
- rd_valid  out  1  high for exactly one cycle, the cycle after an accepted rd_en.
- dbg_start  in  1  pulse that starts a full-bank scan.
- dbg_valid  out  1  high while dbg_addr/dbg_data carry a scanned register.
- dbg_addr  out  ADDR_W  address of the register being scanned.
- dbg_data  out  DATA_W  contents of dbg_addr.
- dbg_done  out  1  one-cycle pulse coincident with the final scan beat.

Behaviour:
- Reset (reset_n low, asynchronous) clears:
  - all registers to 0;
  - rd_data, rd_valid, dbg_valid, dbg_addr, dbg_data and dbg_done to 0;
  - the scan FSM to IDLE.
- Reset asserted mid-scan aborts the scan immediately; no dbg_done is issued.
- Register 0 is hard-wired zero:
  - writes to busC=0 are discarded;
  - reads of address 0 always return 0, including via the bypass path.
- Write: on a rising edge with wr_en=1 and busC!=0, reg[busC] <= wr_data.
- Read: on a rising edge with rd_en=1:
  - rd_data <= reg[busA];
  - rd_valid <= 1 on the following cycle; otherwise rd_valid <= 0.
  - rd_data holds its last value when rd_en=0.
  - Latency is 1 cycle.
- Read/write collision (same-edge rd_en and wr_en with busA==busC!=0): rd_data returns wr_data (write-through bypass), so no stale data is returned.
- Address 0 collision: rd_data=0.
- busA and busC may be equal with only one strobe active; no interaction between the ports in that case.
- Scan FSM, states IDLE and SCAN:
  - IDLE + dbg_start=1 -> SCAN, with index=1 (register 0 is not scanned).
  - SCAN outputs, each cycle: dbg_valid=1, dbg_addr=index, dbg_data=reg[index].
  - dbg_data reflects register contents before any write on the same edge; no bypass on the debug port.
  - index increments by 1 per cycle.
  - When index == 2**ADDR_W-1: dbg_done=1 on that same beat, then -> IDLE.
  - A scan is 2**ADDR_W-1 beats; dbg_valid is first seen one cycle after dbg_start is sampled.
  - dbg_start while in SCAN is ignored; the scan is never restarted.
  - dbg_start on the same edge as the final beat is also ignored.
  - Normal read/write traffic continues unaffected during a scan.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset and x-free reads:
  - Stimulus: reset_n low for 3 cycles mid-operation, release, then rd_en with busA=5.
  - Required: rd_data=0x0000 and rd_valid=1 exactly one cycle later.
- Write then read:
  - Stimulus: wr_en with busC=12, wr_data=0xBEEF; next cycle rd_en with busA=12.
  - Required: rd_data=0xBEEF with rd_valid one cycle after rd_en.
- Collision bypass:
  - Stimulus: same edge rd_en+wr_en, busA=busC=7, wr_data=0x1234, reg7 previously 0x0001.
  - Required: rd_data=0x1234; a read of reg7 next cycle also returns 0x1234.
- Register 0:
  - Stimulus: write 0xFFFF to busC=0, then read busA=0; also a same-edge collision on address 0.
  - Required: rd_data=0x0000 in both cases.
- Full scan:
  - Stimulus: preload reg[i]=i*3 for i=1..63, pulse dbg_start.
  - Required: dbg_valid high for 63 consecutive cycles; dbg_addr runs 1..63 with dbg_data=i*3; dbg_done high only on dbg_addr=63.
  - Also: a second dbg_start at beat 10 is ignored.
- Reset mid-scan:
  - Stimulus: assert reset_n low at beat 20.
  - Required: dbg_valid/dbg_done drop to 0 immediately; FSM in IDLE.
  - Required: a new dbg_start after release performs a complete 63-beat scan.
